// File: rtl/matrix_cfg_loader.sv
// Serial configuration loader for the 5x4 switch-matrix tile: stages routing
// words, checks legality and checksum, then commits the whole set atomically.
module matrix_cfg_loader #(
  parameter int N_TB    = 5,
  parameter int N_LR    = 4,
  parameter int W_ENTRY = 6,
  parameter int W_CSUM  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           cfg_bit,
  input  logic                           cfg_valid,
  output logic [(2*N_TB+2*N_LR)*W_ENTRY-1:0] cfg_bus,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [1:0]                     err_code
);

  localparam int N_ENTRIES = 2*N_TB + 2*N_LR;
  localparam int W_BUS     = N_ENTRIES*W_ENTRY;
  localparam int W_BC      = $clog2((W_CSUM > W_ENTRY) ? W_CSUM : W_ENTRY);
  localparam int W_EC      = $clog2(N_ENTRIES);

  localparam logic [W_BC-1:0] BC_ENTRY_LAST = W_BC'(W_ENTRY-1);
  localparam logic [W_BC-1:0] BC_CSUM_LAST  = W_BC'(W_CSUM-1);
  localparam logic [W_EC-1:0] EC_LAST       = W_EC'(N_ENTRIES-1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CSUM, S_ERR} state_e;
  typedef enum logic [1:0] {E_NONE, E_SIDE, E_RANGE, E_CSUM} err_e;

  state_e                  state;
  logic [W_BC-1:0]         bit_cnt;
  logic [W_EC-1:0]         ent_cnt;
  logic [W_ENTRY-2:0]      word_sh;
  logic [W_CSUM-2:0]       csum_sh;
  logic [W_CSUM-1:0]       acc;
  logic [W_BUS-1:0]        shadow;

  // Words arrive LSB first, so the incoming bit is always the MSB of the
  // word being completed on this edge.
  logic [W_ENTRY-1:0]      word_next;
  logic [W_CSUM-1:0]       csum_next;
  logic [2:0]              side;
  logic [W_ENTRY-4:0]      idx;
  err_e                    word_err;

  assign word_next = {cfg_bit, word_sh};
  assign csum_next = {cfg_bit, csum_sh};
  assign side      = word_next[2:0];
  assign idx       = word_next[W_ENTRY-1:3];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    word_err = E_NONE;
    if (side >= 3'd5)
      word_err = E_SIDE;
    else if ((side == 3'd1 || side == 3'd3) && int'(idx) >= N_TB)
      word_err = E_RANGE;
    else if ((side == 3'd2 || side == 3'd4) && int'(idx) >= N_LR)
      word_err = E_RANGE;
  end

  // NOTE: sequential state is assigned with <= only, so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      ent_cnt  <= '0;
      word_sh  <= '0;
      csum_sh  <= '0;
      acc      <= '0;
      // NOTE: the staging register is reset like any flop; it is small and a
      // clean shadow keeps a restarted load deterministic.
      shadow   <= '0;
      cfg_bus  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= E_NONE;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            state    <= S_LOAD;
            busy     <= 1'b1;
            err      <= 1'b0;
            err_code <= E_NONE;
            bit_cnt  <= '0;
            ent_cnt  <= '0;
            word_sh  <= '0;
            csum_sh  <= '0;
            acc      <= '0;
            shadow   <= '0;
          end
        end

        S_LOAD: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (cfg_valid) begin
            word_sh <= word_next[W_ENTRY-1:1];
            if (bit_cnt == BC_ENTRY_LAST) begin
              bit_cnt <= '0;
              if (word_err != E_NONE) begin
                state    <= S_ERR;
                busy     <= 1'b0;
                err      <= 1'b1;
                err_code <= word_err;
              end else begin
                shadow[ent_cnt*W_ENTRY +: W_ENTRY] <= word_next;
                acc <= acc + {{(W_CSUM-W_ENTRY){1'b0}}, word_next};
                if (ent_cnt == EC_LAST)
                  state <= S_CSUM;
                else
                  ent_cnt <= ent_cnt + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        S_CSUM: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (cfg_valid) begin
            csum_sh <= csum_next[W_CSUM-1:1];
            if (bit_cnt == BC_CSUM_LAST) begin
              bit_cnt <= '0;
              busy    <= 1'b0;
              if (csum_next == acc) begin
                cfg_bus <= shadow;
                done    <= 1'b1;
                state   <= S_IDLE;
              end else begin
                state    <= S_ERR;
                err      <= 1'b1;
                err_code <= E_CSUM;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_cfg_loader.sv
// Self-checking bench for matrix_cfg_loader: directed and randomized loads
// compared against a word-level reference model.
module tb_matrix_cfg_loader;

  localparam int N_ENT = 18;
  localparam int N_BITS = N_ENT*6 + 8;

  typedef logic [5:0] words_t [N_ENT];

  logic         clk = 1'b0;
  logic         rst, start, abort, cfg_bit, cfg_valid;
  logic [107:0] cfg_bus;
  logic         busy, done, err;
  logic [1:0]   err_code;

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  logic [107:0] model_bus;

  matrix_cfg_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_bit(cfg_bit), .cfg_valid(cfg_valid), .cfg_bus(cfg_bus),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: scan words in stream order; the first illegal word ends the
  // load, otherwise the checksum decides.
  function automatic void model(input words_t w, input logic [7:0] cs,
                                output int end_bit, output logic [1:0] code);
    int sum = 0;
    end_bit = N_BITS - 1;
    code    = 2'd0;
    for (int k = 0; k < N_ENT; k++) begin
      int sd = int'(w[k][2:0]);
      int ix = int'(w[k][5:3]);
      logic [1:0] c = 2'd0;
      if (sd >= 5) c = 2'd1;
      else if ((sd == 1 || sd == 3) && ix >= 5) c = 2'd2;
      else if ((sd == 2 || sd == 4) && ix >= 4) c = 2'd2;
      if (c != 2'd0) begin
        end_bit = 6*k + 5;
        code    = c;
        return;
      end
      sum += int'(w[k]);
    end
    if ((sum % 256) != int'(cs)) code = 2'd3;
  endfunction

  function automatic logic [7:0] sum_words(input words_t w);
    int s = 0;
    for (int k = 0; k < N_ENT; k++) s += int'(w[k]);
    return 8'(s % 256);
  endfunction

  function automatic logic [5:0] rand_legal();
    logic [2:0] sd = 3'($urandom_range(0, 4));
    logic [2:0] ix;
    if (sd == 3'd0)                    ix = 3'($urandom_range(0, 7));
    else if (sd == 3'd1 || sd == 3'd3) ix = 3'($urandom_range(0, 4));
    else                               ix = 3'($urandom_range(0, 3));
    return {ix, sd};
  endfunction

  function automatic logic [N_BITS-1:0] make_stream(input words_t w, input logic [7:0] cs);
    logic [N_BITS-1:0] s;
    for (int k = 0; k < N_ENT; k++) s[6*k +: 6] = w[k];
    s[108 +: 8] = cs;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit with_abort);
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_load(input string tag, input words_t w, input logic [7:0] cs,
                          input bit toggle, input bit poke_start, input bit with_abort);
    int end_bit;
    logic [1:0] code;
    logic [N_BITS-1:0] stream;
    logic [107:0] good_bus;
    model(w, cs, end_bit, code);
    stream = make_stream(w, cs);
    good_bus = stream[107:0];
    pulse_start(with_abort);
    check({tag, "_busy_start"}, busy, 1'b1);
    for (int i = 0; i <= end_bit; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = stream[i];
      start     = poke_start && (i == 40);
      tick();
      cfg_valid = 1'b0;
      start     = 1'b0;
      if (toggle && i != end_bit) tick();
    end
    if (code == 2'd0) model_bus = good_bus;
    check({tag, "_done"}, done, code == 2'd0);
    check({tag, "_err"}, err, code != 2'd0);
    check({tag, "_err_code"}, err_code, code);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_bus"}, cfg_bus, model_bus);
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
    if (code != 2'd0) begin
      // ERR must ignore further data
      for (int i = 0; i < 8; i++) begin
        cfg_valid = 1'b1;
        cfg_bit   = 1'($urandom);
        tick();
      end
      cfg_valid = 1'b0;
      check({tag, "_err_hold"}, {busy, err, err_code}, {1'b0, 1'b1, code});
    end
  endtask

  task automatic interrupted_load(input string tag, input bit use_rst);
    words_t w;
    logic [N_BITS-1:0] stream;
    for (int k = 0; k < N_ENT; k++) w[k] = rand_legal();
    stream = make_stream(w, sum_words(w));
    pulse_start(1'b0);
    for (int i = 0; i < 50; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = stream[i];
      tick();
    end
    check({tag, "_busy_mid"}, busy, 1'b1);
    cfg_valid = 1'b1;
    cfg_bit   = stream[50];
    if (use_rst) rst = 1'b1;
    else abort = 1'b1;
    tick();
    rst = 1'b0;
    abort = 1'b0;
    cfg_valid = 1'b0;
    if (use_rst) model_bus = '0;
    check({tag, "_flags"}, {busy, done, err, err_code}, 5'b0);
    check({tag, "_bus"}, cfg_bus, model_bus);
  endtask

  initial begin
    words_t w;
    logic [7:0] cs;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
    model_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_bus", cfg_bus, 108'd0);
    check("reset_flags", {busy, done, err, err_code}, 5'b0);

    for (int k = 0; k < N_ENT; k++) w[k] = 6'h00;
    run_load("all_zero", w, 8'h00, 1'b0, 1'b0, 1'b0);

    w[0] = 6'h13;
    run_load("e0_13", w, 8'h13, 1'b0, 1'b0, 1'b0);
    run_load("e0_13_toggle", w, 8'h13, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < N_ENT; k++) w[k] = 6'h1C;
    run_load("wrap", w, 8'hF8, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < N_ENT; k++) w[k] = 6'h00;
    w[0] = 6'h05;
    run_load("bad_side", w, 8'h05, 1'b0, 1'b0, 1'b0);

    w[0] = 6'h00;
    w[10] = 6'h22;
    run_load("range_right", w, 8'h22, 1'b0, 1'b0, 1'b0);

    w[10] = 6'h00;
    w[0] = 6'h29;
    run_load("range_top", w, 8'h29, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < N_ENT; k++) w[k] = rand_legal();
    run_load("bad_csum", w, sum_words(w) + 8'd1, 1'b0, 1'b0, 1'b0);

    // start during a load is ignored; start+abort in IDLE starts the load
    for (int k = 0; k < N_ENT; k++) w[k] = rand_legal();
    run_load("start_busy", w, sum_words(w), 1'b0, 1'b1, 1'b1);

    interrupted_load("abort50", 1'b0);
    for (int k = 0; k < N_ENT; k++) w[k] = rand_legal();
    run_load("after_abort", w, sum_words(w), 1'b0, 1'b0, 1'b0);

    interrupted_load("rst50", 1'b1);

    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k < N_ENT; k++) w[k] = rand_legal();
      if ($urandom_range(0, 3) == 0) w[$urandom_range(0, N_ENT-1)] = 6'($urandom);
      cs = sum_words(w);
      if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
      run_load($sformatf("rand%0d", n), w, cs, 1'($urandom), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
